ff_chain: RTL

- Parametrised pipeline of DEPTH flip-flop stages per channel, WIDTH channels wide, with optional per-stage inversion.
- Each stage exposes a logic-analyzer tap (stage value OR'd with a per-stage test force).
- Optional power-up gating holds all outputs low until the first reset has been seen.
- Fill counter flags when the pipeline holds only post-reset data.
- Used wherever the design needs multi-cycle delayed or alternating-polarity copies of a signal bundle with observability.

---
 rtl/ff_chain_pkg.sv | 16 +
 rtl/ff_chain_if.sv | 31 +++
 rtl/ff_chain_stage.sv | 26 ++
 rtl/ff_chain.sv | 96 +++++++++
 4 files changed

// File: rtl/ff_chain_pkg.sv
// Shared helpers for the ff_chain delay line: fill-counter sizing and LA tap slicing.
package ff_chain_pkg;

  localparam int unsigned LA_TAP_LSB0 = 0;

  function automatic int fill_cnt_w(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int la_base(input int stage, input int width);
    return LA_TAP_LSB0 + stage * width;
  endfunction

endpackage

// File: rtl/ff_chain_if.sv
// Data/observability bundle of ff_chain. Macro FF_CHAIN_FREEZE_EN adds the freeze input.
interface ff_chain_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]       in;
  logic [DEPTH-1:0]       la_test;
`ifdef FF_CHAIN_FREEZE_EN
  logic                   freeze;
`endif
  logic [WIDTH-1:0]       out;
  logic [DEPTH*WIDTH-1:0] la;
  logic                   armed;
  logic                   fill_done;

  modport master (
    output in, la_test,
`ifdef FF_CHAIN_FREEZE_EN
    output freeze,
`endif
    input  out, la, armed, fill_done
  );

  modport slave (
    input  in, la_test,
`ifdef FF_CHAIN_FREEZE_EN
    input  freeze,
`endif
    output out, la, armed, fill_done
  );
endinterface

// File: rtl/ff_chain_stage.sv
// One WIDTH-bit register stage of the chain, optionally storing the complement, with load enable.
module ff_stage #(
  parameter int WIDTH  = 1,
  parameter bit INVERT = 1'b1
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d, q_q;

  // NOTE: data flops carry no reset; the chain keeps flowing through reset and relies on power-up zero.
  always_comb begin
    q_d = en ? (INVERT ? ~d : d) : q_q;
  end

  // NOTE: sequential state uses non-blocking assignment so every stage samples the pre-edge value.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/ff_chain.sv
// DEPTH-stage, WIDTH-channel delay line with LA taps, power-up gating and fill tracking.
// Optional macro FF_CHAIN_FREEZE_EN adds a freeze input that holds stages and the fill counter.
module ff_chain
  import ff_chain_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int DEPTH       = 4,
  parameter bit INVERT      = 1'b1,
  parameter bit INITIAL_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  ff_chain_if.slave   bus
);

  localparam int CW = fill_cnt_w(DEPTH);

  logic [WIDTH-1:0] stage_in [DEPTH];
  logic [WIDTH-1:0] stage_q  [DEPTH];
  logic             shift_en;
  logic             armed;
  logic             gate_open;

`ifdef FF_CHAIN_FREEZE_EN
  assign shift_en = ~bus.freeze;
`else
  assign shift_en = 1'b1;
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_in[k] = bus.in;
    end else begin : g_link
      assign stage_in[k] = stage_q[k-1];
    end

    ff_stage #(
      .WIDTH  (WIDTH),
      .INVERT (INVERT)
    ) u_stage (
      .clk (clk),
      .en  (shift_en),
      .d   (stage_in[k]),
      .q   (stage_q[k])
    );
  end

  // armed is sticky from the first reset clock; freeze never blocks it.
  if (INITIAL_LOW) begin : g_armed
    logic armed_d, armed_q;
    always_comb begin
      armed_d = armed_q | reset;
    end
    always_ff @(posedge clk) begin
      armed_q <= armed_d;
    end
    assign armed = armed_q;
  end else begin : g_no_armed
    assign armed = 1'b1;
  end

  assign gate_open = armed;

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (reset) begin
      cnt_d = '0;
    end else if (shift_en && (cnt_q != CW'(DEPTH))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  logic [DEPTH*WIDTH-1:0] la_d;

  // NOTE: la_d is fully assigned before the loop so no latch is inferred.
  always_comb begin
    la_d = '0;
    if (gate_open) begin
      for (int k = 0; k < DEPTH; k++) begin
        la_d[la_base(k, WIDTH) +: WIDTH] = stage_q[k] | {WIDTH{bus.la_test[k]}};
      end
    end
  end

  assign bus.la        = la_d;
  assign bus.out       = gate_open ? stage_q[DEPTH-1] : '0;
  assign bus.armed     = armed;
  assign bus.fill_done = (cnt_q == CW'(DEPTH));

endmodule
